capture_buffer_ctrl: RTL and testbench
======================================

Name: capture_buffer_ctrl

Overview:
- Initiator-side controller for the capture buffer responder. It drives that buffer's write and read handshakes.
- Fill: accepts a streaming I/Q sample input, packs each sample into a 32-bit word and writes it to sequential buffer addresses. One write is outstanding at a time.
- Dump: reads the filled addresses back in order and presents each sample on an output stream.
- Sits between the sample front end / readout logic and the capture buffer in the CAF datapath.

Parameters:
- buffer_length, 10, number of buffer entries.
- index_bits, 4, address width; must satisfy 2**index_bits >= buffer_length.
- i_bits, 12, in-phase sample width.
- q_bits, 12, quadrature sample width; i_bits+q_bits <= 32.
- resp_timeout, 15, cycles to wait for bvalid or rvalid before flagging an error.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start_fill  in  1  pulse; begin fill at address 0 (ignored unless IDLE).
- start_dump  in  1  pulse; begin readback of entries 0..fill_count-1 (ignored unless IDLE).
- in_i  in  i_bits  signed sample I.
- in_q  in  q_bits  signed sample Q.
- in_valid  in  1  input sample valid.
- in_ready  out  1  input sample accepted when in_valid & in_ready.
- out_i  out  i_bits  signed readback I.
- out_q  out  q_bits  signed readback Q.
- out_valid  out  1  readback sample valid.
- out_ready  in  1  downstream accepts readback sample.
- m_axi_waddr  out  index_bits  write address.
- m_axi_wdata  out  32  write data.
- m_axi_wvalid  out  1  write request.
- s_axi_wready  in  1  responder write ready.
- s_axi_bvalid  in  1  write response valid.
- s_axi_bresp  in  1  write response; 1 = error.
- m_axi_bready  out  1  write response ready.
- m_axi_raddr  out  index_bits  read address.
- m_axi_rvalid  out  1  read request valid.
- m_axi_rready  out  1  read request ready (driven with rvalid).
- s_axi_rvalid  in  1  read data valid.
- i  in  i_bits  read data I.
- q  in  q_bits  read data Q.
- busy  out  1  FSM not IDLE.
- fill_count  out  index_bits+1  number of entries written in the last fill.
- err  out  1  sticky; set on timeout or bresp=1; cleared by next start_fill/start_dump.

Behaviour:
- Reset values: all outputs 0, FSM = IDLE, address counter = 0, timeout counter = 0.
- Reset is asynchronous. Assertion mid-transaction aborts immediately with no further requests issued. fill_count returns to 0.
- States: IDLE, W_GET, W_REQ, W_RESP, R_REQ, R_WAIT, R_OUT, and ERR (one cycle, then IDLE).
- IDLE:
  - start_fill: clear addr, fill_count and err; go to W_GET.
  - start_dump with fill_count > 0: clear addr and err; go to R_REQ.
  - start_dump with fill_count = 0: ignored.
  - Both starts in the same cycle: start_fill wins.
- W_GET:
  - in_ready = 1.
  - On accept: m_axi_wdata = zero-extended {in_i, in_q}, with in_i at [i_bits+q_bits-1:q_bits] and in_q at [q_bits-1:0]. m_axi_waddr = addr. Go to W_REQ.
- W_REQ:
  - m_axi_wvalid held until the cycle wvalid & wready; deasserted the next cycle.
  - Address and data are stable while wvalid is high.
  - Go to W_RESP.
- W_RESP:
  - m_axi_bready = 1; wait for s_axi_bvalid.
  - bresp = 0: fill_count <= addr+1.
    - If addr = buffer_length-1, go to IDLE (no wrap).
    - Otherwise addr++ and go to W_GET.
  - bresp = 1: go to ERR.
- R_REQ:
  - Assert m_axi_rvalid and m_axi_rready for exactly one cycle with m_axi_raddr = addr.
  - Go to R_WAIT.
- R_WAIT:
  - Wait for s_axi_rvalid; the nominal responder latency is 2 cycles after the request.
  - Capture i and q into out_i/out_q; go to R_OUT.
- R_OUT:
  - out_valid held until out_ready; out_i/out_q stable meanwhile.
  - On accept: if addr = fill_count-1, go to IDLE; otherwise addr++ and go to R_REQ.
- Timeout:
  - The counter resets on entering W_RESP or R_WAIT and counts cycles spent there.
  - Reaching resp_timeout: go to ERR and set err.
  - A late response arriving in IDLE is ignored.
- Spurious inputs: s_axi_bvalid or s_axi_rvalid outside their wait states are ignored.
- Throughput: one write per ≥3 cycles, one read per ≥4 cycles.

Decomposition:
- Shared package caf_capture_pkg:
  - FSM state enum.
  - Word-pack function {i, q} to 32 bits, plus its unpack counterpart.
  - Constant for bresp error encoding.
- Sub-module: capture_resp_timer, a loadable down-counter with an expire flag, reused by both wait states.

Test Plan:
- Fill from reset against a 2-cycle responder model: start_fill, then 10 samples I=n, Q=-n → writes at addr 0..9 with wdata = {8'h0, n[11:0], -n[11:0]}. fill_count=10, busy drops, no 11th write.
- Write backpressure: hold s_axi_wready=0 for 4 cycles at addr 3 → wvalid, waddr and wdata stable for all 5 cycles; exactly one write occurs.
- Dump: after the fill, start_dump with out_ready toggling 1/0 → out stream returns I=0..9, Q=0..-9 in order; out_valid never drops without acceptance.
- Timeout: responder never asserts bvalid on the first write → err=1 at cycle resp_timeout in W_RESP, FSM back in IDLE, in_ready=0.
- bresp=1 on addr 2 → err=1, fill_count=2; a following start_dump reads only addrs 0..1.
- Async reset: assert rst_n=0 in R_WAIT → all outputs 0 immediately, no request after release; start_dump is then ignored (fill_count=0).

Source files
------------

// File: rtl/caf_capture_pkg.sv
// Shared definitions for the capture buffer controller: FSM state encodings,
// I/Q word packing helpers and the write-response error code.
package caf_capture_pkg;

    localparam int unsigned STATE_BITS = 3;

    localparam logic [STATE_BITS-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_BITS-1:0] ST_W_GET  = 3'd1;
    localparam logic [STATE_BITS-1:0] ST_W_REQ  = 3'd2;
    localparam logic [STATE_BITS-1:0] ST_W_RESP = 3'd3;
    localparam logic [STATE_BITS-1:0] ST_R_REQ  = 3'd4;
    localparam logic [STATE_BITS-1:0] ST_R_WAIT = 3'd5;
    localparam logic [STATE_BITS-1:0] ST_R_OUT  = 3'd6;
    localparam logic [STATE_BITS-1:0] ST_ERR    = 3'd7;

    localparam logic BRESP_ERR = 1'b1;

    // Low-order mask of w ones; w is always below 32 since i_bits+q_bits <= 32.
    function automatic logic [31:0] field_mask(input int unsigned w);
        return (32'(1) << w) - 32'(1);
    endfunction

    // {i, q} zero-extended to 32 bits, q in the low bits.
    function automatic logic [31:0] pack_iq(input logic [31:0] i_val, input logic [31:0] q_val,
                                            input int unsigned i_w, input int unsigned q_w);
        return ((i_val & field_mask(i_w)) << q_w) | (q_val & field_mask(q_w));
    endfunction

    function automatic logic [31:0] unpack_i(input logic [31:0] word,
                                             input int unsigned i_w, input int unsigned q_w);
        return (word >> q_w) & field_mask(i_w);
    endfunction

    function automatic logic [31:0] unpack_q(input logic [31:0] word, input int unsigned q_w);
        return word & field_mask(q_w);
    endfunction

endpackage

// File: rtl/capture_buffer_ctrl_if.sv
// Write/read handshake bundle between the controller (master) and the
// capture buffer responder (slave).
interface capture_buffer_ctrl_if #(
    parameter int unsigned index_bits = 4,
    parameter int unsigned i_bits     = 12,
    parameter int unsigned q_bits     = 12
) ();
    logic [index_bits-1:0]    m_axi_waddr;
    logic [31:0]              m_axi_wdata;
    logic                     m_axi_wvalid;
    logic                     s_axi_wready;
    logic                     s_axi_bvalid;
    logic                     s_axi_bresp;
    logic                     m_axi_bready;
    logic [index_bits-1:0]    m_axi_raddr;
    logic                     m_axi_rvalid;
    logic                     m_axi_rready;
    logic                     s_axi_rvalid;
    logic signed [i_bits-1:0] i;
    logic signed [q_bits-1:0] q;

    modport master (
        output m_axi_waddr, m_axi_wdata, m_axi_wvalid, m_axi_bready,
               m_axi_raddr, m_axi_rvalid, m_axi_rready,
        input  s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_rvalid, i, q
    );

    modport slave (
        input  m_axi_waddr, m_axi_wdata, m_axi_wvalid, m_axi_bready,
               m_axi_raddr, m_axi_rvalid, m_axi_rready,
        output s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_rvalid, i, q
    );
endinterface

// File: rtl/capture_resp_timer.sv
// Loadable down-counter for response timeouts.
//   load_i/load_val_i : reload the counter (on entry to a wait state)
//   expired_o         : counter has reached zero
module capture_resp_timer #(
    parameter int unsigned cnt_bits = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic [cnt_bits-1:0] load_val_i,
    output logic                expired_o
);
    logic [cnt_bits-1:0] cnt_q;
    logic [cnt_bits-1:0] cnt_d;
    logic                expired_q;

    // Count down to zero and hold there.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - cnt_bits'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= (cnt_d == '0);
        end
    end

    assign expired_o = expired_q;
endmodule

// File: rtl/capture_buffer_ctrl.sv
// Capture buffer initiator: fills the buffer from the I/Q sample stream and
// dumps the filled entries back out as a sample stream.
//   start_fill/start_dump : IDLE-only command pulses
//   in_*                  : sample input stream (valid/ready)
//   out_*                 : readback sample stream (valid/ready)
//   bus                   : write/read handshakes to the capture buffer
//   busy/fill_count/err   : status; err is sticky until the next start
module capture_buffer_ctrl
    import caf_capture_pkg::*;
#(
    parameter int unsigned buffer_length = 10,
    parameter int unsigned index_bits    = 4,
    parameter int unsigned i_bits        = 12,
    parameter int unsigned q_bits        = 12,
    parameter int unsigned resp_timeout  = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_fill,
    input  logic                    start_dump,
    input  logic signed [i_bits-1:0] in_i,
    input  logic signed [q_bits-1:0] in_q,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [i_bits-1:0] out_i,
    output logic signed [q_bits-1:0] out_q,
    output logic                    out_valid,
    input  logic                    out_ready,
    capture_buffer_ctrl_if.master   bus,
    output logic                    busy,
    output logic [index_bits:0]     fill_count,
    output logic                    err
);
    localparam int unsigned CNT_W = index_bits + 1;
    localparam int unsigned TMR_W = $clog2(resp_timeout + 1);
    localparam logic [index_bits-1:0] LAST_ADDR = index_bits'(buffer_length - 1);

    logic [STATE_BITS-1:0]   state_q, state_d;
    logic [index_bits-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]        fill_count_q, fill_count_d;
    logic                    err_q, err_d;
    logic [31:0]             wdata_q, wdata_d;
    logic signed [i_bits-1:0] out_i_q, out_i_d;
    logic signed [q_bits-1:0] out_q_q, out_q_d;
    logic                    in_ready_q, wvalid_q, bready_q, rvalid_q, out_valid_q, busy_q;
    logic                    tmr_load;
    logic                    tmr_expired;

    capture_resp_timer #(.cnt_bits(TMR_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (TMR_W'(resp_timeout - 1)),
        .expired_o  (tmr_expired)
    );

    // Next-state and datapath updates.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        fill_count_d = fill_count_q;
        err_d        = err_q;
        wdata_d      = wdata_q;
        out_i_d      = out_i_q;
        out_q_d      = out_q_q;
        tmr_load     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_fill) begin
                    addr_d       = '0;
                    fill_count_d = '0;
                    err_d        = 1'b0;
                    state_d      = ST_W_GET;
                end else if (start_dump && fill_count_q != '0) begin
                    addr_d  = '0;
                    err_d   = 1'b0;
                    state_d = ST_R_REQ;
                end
            end
            ST_W_GET: begin
                if (in_valid) begin
                    wdata_d = pack_iq(32'(in_i), 32'(in_q), i_bits, q_bits);
                    state_d = ST_W_REQ;
                end
            end
            ST_W_REQ: begin
                if (bus.s_axi_wready) begin
                    tmr_load = 1'b1;
                    state_d  = ST_W_RESP;
                end
            end
            ST_W_RESP: begin
                if (bus.s_axi_bvalid) begin
                    if (bus.s_axi_bresp == BRESP_ERR) begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end else begin
                        fill_count_d = CNT_W'(addr_q) + CNT_W'(1);
                        if (addr_q == LAST_ADDR) begin
                            state_d = ST_IDLE;
                        end else begin
                            addr_d  = addr_q + index_bits'(1);
                            state_d = ST_W_GET;
                        end
                    end
                end else if (tmr_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end
            end
            ST_R_REQ: begin
                tmr_load = 1'b1;
                state_d  = ST_R_WAIT;
            end
            ST_R_WAIT: begin
                if (bus.s_axi_rvalid) begin
                    out_i_d = bus.i;
                    out_q_d = bus.q;
                    state_d = ST_R_OUT;
                end else if (tmr_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end
            end
            ST_R_OUT: begin
                if (out_ready) begin
                    if (CNT_W'(addr_q) == fill_count_q - CNT_W'(1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        addr_d  = addr_q + index_bits'(1);
                        state_d = ST_R_REQ;
                    end
                end
            end
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath and Moore outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            fill_count_q <= '0;
            err_q        <= 1'b0;
            wdata_q      <= '0;
            out_i_q      <= '0;
            out_q_q      <= '0;
            in_ready_q   <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            rvalid_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            fill_count_q <= fill_count_d;
            err_q        <= err_d;
            wdata_q      <= wdata_d;
            out_i_q      <= out_i_d;
            out_q_q      <= out_q_d;
            in_ready_q   <= (state_d == ST_W_GET);
            wvalid_q     <= (state_d == ST_W_REQ);
            bready_q     <= (state_d == ST_W_RESP);
            rvalid_q     <= (state_d == ST_R_REQ);
            out_valid_q  <= (state_d == ST_R_OUT);
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    assign in_ready         = in_ready_q;
    assign out_i            = out_i_q;
    assign out_q            = out_q_q;
    assign out_valid        = out_valid_q;
    assign busy             = busy_q;
    assign fill_count       = fill_count_q;
    assign err              = err_q;
    // addr_q only moves in W_RESP/R_OUT, so it is stable across each request.
    assign bus.m_axi_waddr  = addr_q;
    assign bus.m_axi_wdata  = wdata_q;
    assign bus.m_axi_wvalid = wvalid_q;
    assign bus.m_axi_bready = bready_q;
    assign bus.m_axi_raddr  = addr_q;
    assign bus.m_axi_rvalid = rvalid_q;
    assign bus.m_axi_rready = rvalid_q;
endmodule

// File: tb/tb_capture_buffer_ctrl.sv
// Directed bench for capture_buffer_ctrl with a 2-cycle buffer responder model.
module tb_capture_buffer_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_fill = 1'b0;
    logic start_dump = 1'b0;
    logic signed [11:0] in_i = '0;
    logic signed [11:0] in_q = '0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic signed [11:0] out_i;
    logic signed [11:0] out_q;
    logic out_valid;
    logic out_ready = 1'b0;
    logic busy;
    logic [4:0] fill_count;
    logic err;

    int checks = 0;
    int errors = 0;

    capture_buffer_ctrl_if #(.index_bits(4), .i_bits(12), .q_bits(12)) bus ();

    capture_buffer_ctrl #(
        .buffer_length(10), .index_bits(4), .i_bits(12), .q_bits(12), .resp_timeout(15)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_fill(start_fill), .start_dump(start_dump),
        .in_i(in_i), .in_q(in_q), .in_valid(in_valid), .in_ready(in_ready),
        .out_i(out_i), .out_q(out_q), .out_valid(out_valid), .out_ready(out_ready),
        .bus(bus), .busy(busy), .fill_count(fill_count), .err(err)
    );

    always #5 clk = ~clk;

    // ---------------- responder model ----------------
    logic [31:0] mem [0:15];
    int b_cnt = 0;
    int b_addr = 0;
    int r_cnt = 0;
    int r_addr = 0;
    bit b_en = 1'b1;
    int b_err_addr = -1;
    int stall_addr = -1;
    int stall_left = 0;
    logic [3:0] stall_addr4;
    logic [31:0] rd_word;

    logic [3:0]  w_addr_log [$];
    logic [31:0] w_data_log [$];
    logic [3:0]  r_addr_log [$];
    logic signed [11:0] o_i_log [$];
    logic signed [11:0] o_q_log [$];

    assign stall_addr4 = 4'(stall_addr);
    assign bus.s_axi_wready = !(bus.m_axi_wvalid && stall_addr >= 0 &&
                                bus.m_axi_waddr == stall_addr4 && stall_left != 0);
    assign rd_word = mem[r_addr];

    always @(posedge clk) begin
        if (bus.m_axi_wvalid && stall_addr >= 0 && bus.m_axi_waddr == stall_addr4 && stall_left != 0)
            stall_left <= stall_left - 1;
        if (bus.m_axi_wvalid && bus.s_axi_wready) begin
            mem[bus.m_axi_waddr] <= bus.m_axi_wdata;
            w_addr_log.push_back(bus.m_axi_waddr);
            w_data_log.push_back(bus.m_axi_wdata);
            b_cnt  <= 2;
            b_addr <= int'(bus.m_axi_waddr);
        end else if (b_cnt != 0) begin
            b_cnt <= b_cnt - 1;
        end
        bus.s_axi_bvalid <= (b_cnt == 1) && b_en;
        bus.s_axi_bresp  <= (b_addr == b_err_addr);
        if (bus.m_axi_rvalid) begin
            r_addr_log.push_back(bus.m_axi_raddr);
            r_cnt  <= 2;
            r_addr <= int'(bus.m_axi_raddr);
        end else if (r_cnt != 0) begin
            r_cnt <= r_cnt - 1;
        end
        bus.s_axi_rvalid <= (r_cnt == 1);
        bus.i <= rd_word[23:12];
        bus.q <= rd_word[11:0];
    end

    // ---------------- monitors (sampled mid-cycle) ----------------
    int stall_cycles = 0, stall_unstable = 0, bready_cycles = 0;
    int drops = 0, rr_bad = 0;
    logic [31:0] stall_data;
    logic prev_ov = 1'b0, prev_acc = 1'b0;
    logic signed [11:0] prev_oi, prev_oq;

    always @(negedge clk) begin
        if (bus.m_axi_wvalid && stall_addr >= 0 && bus.m_axi_waddr == stall_addr4) begin
            if (stall_cycles == 0) stall_data = bus.m_axi_wdata;
            else if (bus.m_axi_wdata !== stall_data) stall_unstable++;
            stall_cycles++;
        end
        if (bus.m_axi_bready) bready_cycles++;
        if (bus.m_axi_rready !== bus.m_axi_rvalid) rr_bad++;
        if (prev_ov && !prev_acc && rst_n &&
            (!out_valid || out_i !== prev_oi || out_q !== prev_oq)) drops++;
        if (out_valid && out_ready) begin
            o_i_log.push_back(out_i);
            o_q_log.push_back(out_q);
        end
        prev_ov  = out_valid;
        prev_acc = out_valid && out_ready;
        prev_oi  = out_i;
        prev_oq  = out_q;
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_start(input bit f, input bit d);
        @(posedge clk); #1;
        start_fill = f; start_dump = d;
        @(posedge clk); #1;
        start_fill = 1'b0; start_dump = 1'b0;
    endtask

    task automatic send_sample(input int n, output bit ok);
        in_i = 12'(n); in_q = 12'(-n); in_valid = 1'b1; ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (fill_count !== 5'd0) begin errors++; $display("FAIL reset_fill_count got %0d want 0", fill_count); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if ({in_ready, out_valid, bus.m_axi_wvalid, bus.m_axi_rvalid, bus.m_axi_bready} !== 5'b0) begin
            errors++; $display("FAIL reset_handshakes got %b want 00000",
                {in_ready, out_valid, bus.m_axi_wvalid, bus.m_axi_rvalid, bus.m_axi_bready}); end
        checks++; if (bus.m_axi_wdata !== 32'h0 || out_i !== 12'sd0 || out_q !== 12'sd0) begin
            errors++; $display("FAIL reset_data got wdata=%h out_i=%0d out_q=%0d want 0", bus.m_axi_wdata, out_i, out_q); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_fill_backpressure();
        bit ok;
        int nok = 0;
        logic [11:0] ei, eq;
        stall_addr = 3; stall_left = 4; stall_cycles = 0; stall_unstable = 0;
        pulse_start(1'b1, 1'b0);
        for (int n = 0; n < 10; n++) begin
            send_sample(n, ok);
            if (ok) nok++;
        end
        wait_idle(200, ok);
        checks++; if (!ok || nok != 10) begin errors++; $display("FAIL fill_done got idle=%0b accepted=%0d want 1/10", ok, nok); end
        repeat (10) @(negedge clk);
        checks++; if (w_addr_log.size() != 10) begin errors++; $display("FAIL fill_write_count got %0d want 10", w_addr_log.size()); end
        for (int n = 0; n < 10 && n < w_addr_log.size(); n++) begin
            ei = 12'(n); eq = 12'(-n);
            checks++;
            if (w_addr_log[n] !== 4'(n) || w_data_log[n] !== {8'h00, ei, eq}) begin
                errors++; $display("FAIL fill_write%0d got addr=%0d data=%h want addr=%0d data=%h",
                    n, w_addr_log[n], w_data_log[n], n, {8'h00, ei, eq}); end
        end
        checks++; if (fill_count !== 5'd10) begin errors++; $display("FAIL fill_count got %0d want 10", fill_count); end
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL fill_idle got busy=%b in_ready=%b err=%b want 0/0/0", busy, in_ready, err); end
        checks++; if (stall_cycles != 5 || stall_unstable != 0) begin
            errors++; $display("FAIL stall_hold got wvalid_cycles=%0d unstable=%0d want 5/0", stall_cycles, stall_unstable); end
        stall_addr = -1;
    endtask

    task automatic test_dump();
        bit done = 1'b0;
        logic signed [11:0] eq;
        r_addr_log.delete(); o_i_log.delete(); o_q_log.delete(); drops = 0; rr_bad = 0;
        pulse_start(1'b0, 1'b1);
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            out_ready = ~out_ready;
            if (!busy) begin done = 1'b1; break; end
        end
        out_ready = 1'b0;
        checks++; if (!done) begin errors++; $display("FAIL dump_done got busy=%b want 0", busy); end
        checks++; if (o_i_log.size() != 10 || r_addr_log.size() != 10) begin
            errors++; $display("FAIL dump_count got out=%0d reads=%0d want 10/10", o_i_log.size(), r_addr_log.size()); end
        for (int n = 0; n < 10 && n < o_i_log.size() && n < r_addr_log.size(); n++) begin
            eq = 12'(-n);
            checks++;
            if (o_i_log[n] !== 12'(n) || o_q_log[n] !== eq || r_addr_log[n] !== 4'(n)) begin
                errors++; $display("FAIL dump_sample%0d got i=%0d q=%0d raddr=%0d want i=%0d q=%0d raddr=%0d",
                    n, o_i_log[n], o_q_log[n], r_addr_log[n], n, eq, n); end
        end
        checks++; if (drops != 0 || rr_bad != 0) begin
            errors++; $display("FAIL dump_stream got drops=%0d rready_mismatch=%0d want 0/0", drops, rr_bad); end
    endtask

    task automatic test_timeout();
        bit ok;
        b_en = 1'b0; w_addr_log.delete(); w_data_log.delete();
        pulse_start(1'b1, 1'b0);
        bready_cycles = 0;
        send_sample(5, ok);
        wait_idle(100, ok);
        checks++; if (!ok || err !== 1'b1) begin errors++; $display("FAIL timeout_err got idle=%0b err=%b want 1/1", ok, err); end
        checks++; if (bready_cycles != 15) begin errors++; $display("FAIL timeout_cycles got %0d want 15", bready_cycles); end
        checks++; if (in_ready !== 1'b0 || fill_count !== 5'd0 || w_addr_log.size() != 1) begin
            errors++; $display("FAIL timeout_state got in_ready=%b fill_count=%0d writes=%0d want 0/0/1",
                in_ready, fill_count, w_addr_log.size()); end
        b_en = 1'b1;
    endtask

    task automatic test_bresp_err();
        bit ok;
        logic signed [11:0] eq;
        b_err_addr = 2;
        pulse_start(1'b1, 1'b0);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL bresp_err_clear got %b want 0", err); end
        for (int n = 0; n < 3; n++) send_sample(n, ok);
        wait_idle(100, ok);
        checks++; if (!ok || err !== 1'b1 || fill_count !== 5'd2) begin
            errors++; $display("FAIL bresp_err got idle=%0b err=%b fill_count=%0d want 1/1/2", ok, err, fill_count); end
        b_err_addr = -1;
        r_addr_log.delete(); o_i_log.delete(); o_q_log.delete();
        out_ready = 1'b1;
        pulse_start(1'b0, 1'b1);
        wait_idle(100, ok);
        out_ready = 1'b0;
        checks++; if (!ok || err !== 1'b0 || r_addr_log.size() != 2 || o_i_log.size() != 2) begin
            errors++; $display("FAIL bresp_dump got idle=%0b err=%b reads=%0d outs=%0d want 1/0/2/2",
                ok, err, r_addr_log.size(), o_i_log.size()); end
        for (int n = 0; n < 2 && n < r_addr_log.size() && n < o_i_log.size(); n++) begin
            eq = 12'(-n);
            checks++;
            if (r_addr_log[n] !== 4'(n) || o_i_log[n] !== 12'(n) || o_q_log[n] !== eq) begin
                errors++; $display("FAIL bresp_dump%0d got raddr=%0d i=%0d q=%0d want %0d/%0d/%0d",
                    n, r_addr_log[n], o_i_log[n], o_q_log[n], n, n, eq); end
        end
    endtask

    task automatic test_async_reset();
        bit seen = 1'b0;
        int nreq;
        int ov_seen = 0;
        pulse_start(1'b0, 1'b1);
        for (int c = 0; c < 20; c++) begin
            if (bus.m_axi_rvalid) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!seen) begin errors++; $display("FAIL areset_req got no read request want one"); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, err, out_valid, bus.m_axi_rvalid, bus.m_axi_rready, in_ready} !== 6'b0 || fill_count !== 5'd0) begin
            errors++; $display("FAIL areset_outputs got flags=%b fill_count=%0d want 0/0",
                {busy, err, out_valid, bus.m_axi_rvalid, bus.m_axi_rready, in_ready}, fill_count); end
        nreq = r_addr_log.size();
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid || busy) ov_seen++;
        end
        checks++; if (ov_seen != 0) begin errors++; $display("FAIL areset_late_resp got active_cycles=%0d want 0", ov_seen); end
        pulse_start(1'b0, 1'b1);
        repeat (6) @(negedge clk);
        checks++; if (busy !== 1'b0 || r_addr_log.size() != nreq) begin
            errors++; $display("FAIL areset_dump_ignored got busy=%b reads=%0d want 0/%0d", busy, r_addr_log.size(), nreq); end
    endtask

    initial begin
        test_reset();
        test_fill_backpressure();
        test_dump();
        test_timeout();
        test_bresp_err();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
